// File: rtl/ex_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: MD opcodes,
// forwarding-select codes and the iteration FSM states.
package ex_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6,
    MD_MT    = 3'd7
  } md_op_t;

  typedef enum logic [2:0] {
    FWD_IDEX  = 3'd0,
    FWD_EXMEM = 3'd1,
    FWD_WB    = 3'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply / restoring divide on magnitudes.
// Latency NBITS steps; with MD_EARLY_OUT_EN a multiply flags o_last once the remaining multiplier bits are zero.
// No backpressure: the controlling FSM pulses i_load once, then holds i_step high until o_last.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [NBITS-1:0]   i_mcand,
  input  logic [NBITS-1:0]   i_mq,
  output logic [2*NBITS-1:0] o_acc,
  output logic [NBITS-1:0]   o_mq,
  output logic               o_last
);

  localparam int CW = $clog2(NBITS);

  logic [2*NBITS-1:0] acc;
  logic [2*NBITS-1:0] mcand;
  logic [NBITS-1:0]   mq;
  logic [CW-1:0]      count;
  logic [NBITS+1:0]   trial;
  logic               fits;

  // Divide: acc[NBITS-1:0] is the partial remainder, mq the dividend/quotient, mcand the divisor.
  assign trial = {1'b0, acc[NBITS-1:0], mq[NBITS-1]} - {2'b00, mcand[NBITS-1:0]};
  assign fits  = ~trial[NBITS+1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      count <= '0;
    end else if (i_load) begin
      acc   <= '0;
      mcand <= {{NBITS{1'b0}}, i_mcand};
      mq    <= i_mq;
      count <= '0;
    end else if (i_step) begin
      count <= count + CW'(1);
      if (i_div) begin
        acc[NBITS-1:0] <= fits ? trial[NBITS-1:0] : {acc[NBITS-2:0], mq[NBITS-1]};
        mq             <= {mq[NBITS-2:0], fits};
      end else begin
        if (mq[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mq    <= mq >> 1;
      end
    end
  end

  always_comb begin
    o_last = (count == CW'(NBITS - 1));
`ifdef MD_EARLY_OUT_EN
    if (!i_div && (mq[NBITS-1:1] == '0)) o_last = 1'b1;
`endif
  end

  assign o_acc = acc;
  assign o_mq  = mq;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO, MFHI/MFLO and own operand forwarding.
// Latency: start edge to HI/LO written is NBITS+1 edges (shorter multiply when MD_EARLY_OUT_EN is defined).
// Backpressure: o_stall holds the front end while busy and the EX instruction is any MD op; flush aborts.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int NBITS         = 32,
  parameter int REGS          = 5,
  parameter int CORTOCIRCUITO = 3,
  parameter int MD_OPW        = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  input  logic                     i_flush,
  input  logic [MD_OPW-1:0]        i_md_op,
  input  logic                     i_mt_lo,
  input  logic [CORTOCIRCUITO-1:0] i_corto_cir_regA,
  input  logic [CORTOCIRCUITO-1:0] i_corto_cir_regB,
  input  logic [NBITS-1:0]         i_reg1,
  input  logic [NBITS-1:0]         i_reg2,
  input  logic [NBITS-1:0]         i_ex_mem_reg,
  input  logic [NBITS-1:0]         i_wb_write_data,
  output logic                     o_stall,
  output logic                     o_busy,
  output logic [NBITS-1:0]         o_md_result,
  output logic [NBITS-1:0]         o_hi,
  output logic [NBITS-1:0]         o_lo
);

  function automatic logic [NBITS-1:0] fwd_mux(input logic [CORTOCIRCUITO-1:0] sel,
                                               input logic [NBITS-1:0] idex,
                                               input logic [NBITS-1:0] exmem,
                                               input logic [NBITS-1:0] wb);
    case (sel)
      CORTOCIRCUITO'(FWD_EXMEM): fwd_mux = exmem;
      CORTOCIRCUITO'(FWD_WB):    fwd_mux = wb;
      default:                   fwd_mux = idex;
    endcase
  endfunction

  md_state_t          state, state_n;
  md_op_t             op;
  logic [NBITS-1:0]   opa, opb, mag_a, mag_b;
  logic               is_start_op, is_sgn, is_div_op, neg_a, neg_b;
  logic               start, mt_wr, load, step, commit, last;
  logic               md_div, neg_q, neg_r, div0;
  logic [2*NBITS-1:0] acc, prod;
  logic [NBITS-1:0]   mq, quo, rem, hi_n, lo_n, hi, lo;
  logic               unused_regs;

  assign unused_regs = ^REGS[0];

  assign op  = md_op_t'(i_md_op);
  assign opa = fwd_mux(i_corto_cir_regA, i_reg1, i_ex_mem_reg, i_wb_write_data);
  assign opb = fwd_mux(i_corto_cir_regB, i_reg2, i_ex_mem_reg, i_wb_write_data);

  assign is_start_op = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign is_sgn      = (op == MD_MULT) || (op == MD_DIV);
  assign is_div_op   = (op == MD_DIV)  || (op == MD_DIVU);
  assign neg_a       = is_sgn & opa[NBITS-1];
  assign neg_b       = is_sgn & opb[NBITS-1];
  assign mag_a       = neg_a ? -opa : opa;
  assign mag_b       = neg_b ? -opb : opb;

  assign o_busy  = (state != IDLE);
  assign o_stall = i_valid & o_busy & (op != MD_NONE);
  assign start   = i_valid & is_start_op & ~i_flush & ~o_stall;
  assign mt_wr   = i_valid & (op == MD_MT) & ~i_flush & ~o_stall;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        load    = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Flush wins over both the iteration and the final HI/LO write.
    if (i_flush) begin
      state_n = IDLE;
      step    = 1'b0;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      md_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        md_div <= is_div_op;
        neg_q  <= neg_a ^ neg_b;
        neg_r  <= neg_a;
        div0   <= (opb == '0);
      end
    end
  end

  muldiv_iter #(.NBITS(NBITS)) u_iter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (load),
    .i_step    (step),
    .i_div     (md_div),
    .i_mcand   (is_div_op ? mag_b : mag_a),
    .i_mq      (is_div_op ? mag_a : mag_b),
    .o_acc     (acc),
    .o_mq      (mq),
    .o_last    (last)
  );

  // Divide by zero leaves the dividend magnitude as remainder; only the quotient needs forcing.
  assign prod = neg_q ? -acc : acc;
  assign quo  = div0 ? '1 : (neg_q ? -mq : mq);
  assign rem  = neg_r ? -acc[NBITS-1:0] : acc[NBITS-1:0];
  assign hi_n = md_div ? rem : prod[2*NBITS-1:NBITS];
  assign lo_n = md_div ? quo : prod[NBITS-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= hi_n;
      lo <= lo_n;
    end else if (mt_wr) begin
      if (i_mt_lo) lo <= opa;
      else         hi <= opa;
    end
  end

  assign o_hi        = hi;
  assign o_lo        = lo;
  assign o_md_result = (op == MD_MFHI) ? hi : (op == MD_MFLO) ? lo : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;
  import ex_pkg::*;

  localparam int NBITS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, mt_lo;
  logic [2:0]  md_op, sel_a, sel_b;
  logic [31:0] reg1, reg2, exmem, wb;
  logic        stall, busy;
  logic [31:0] md_result, hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.NBITS(NBITS)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_valid          (valid),
    .i_flush          (flush),
    .i_md_op          (md_op),
    .i_mt_lo          (mt_lo),
    .i_corto_cir_regA (sel_a),
    .i_corto_cir_regB (sel_b),
    .i_reg1           (reg1),
    .i_reg2           (reg2),
    .i_ex_mem_reg     (exmem),
    .i_wb_write_data  (wb),
    .o_stall          (stall),
    .o_busy           (busy),
    .o_md_result      (md_result),
    .o_hi             (hi),
    .o_lo             (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result {HI,LO} computed with native 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 3'd1) return sa * sb;
    if (op == 3'd2) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (op == 3'd3) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Busy cycles seen by an MD op issued right after the start.
  function automatic int exp_stalls(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] m;
    int bl;
    m  = (op == 3'd1 && b[31]) ? -b : b;
    bl = 1;
    while (bl < 32 && (m >> bl) != 0) bl++;
`ifdef MD_EARLY_OUT_EN
    if (op == 3'd1 || op == 3'd2) return bl + 1;
`endif
    return NBITS + 1;
  endfunction

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; md_op = 3'd0; mt_lo = 1'b0;
    sel_a = 3'd0; sel_b = 3'd0;
  endtask

  task automatic put_operands(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] sa, input logic [2:0] sb);
    reg1 = $urandom; reg2 = $urandom; exmem = $urandom; wb = $urandom;
    sel_a = sa; sel_b = sb;
    if (sa == 3'd1) exmem = a; else if (sa == 3'd2) wb = a; else reg1 = a;
    if (sb == 3'd1) exmem = b; else if (sb == 3'd2) wb = b; else reg2 = b;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] sa, input logic [2:0] sb, input bit gap);
    logic [63:0] r;
    int n, want;
    r    = ref_md(op, a, b);
    want = exp_stalls(op, b);
    @(negedge clk);
    valid = 1'b1; md_op = op; put_operands(a, b, sa, sb);
    #1 check({tag, " start_stall"}, stall, 0);
    @(negedge clk);
    sel_a = 3'd0; sel_b = 3'd0; reg1 = $urandom; reg2 = $urandom;
    if (gap) begin
      md_op = 3'd0;
      #1;
      check({tag, " nonmd_stall"}, stall, 0);
      check({tag, " busy"}, busy, 1);
      @(negedge clk);
      want--;
    end
    md_op = 3'd6;
    n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, n, want);
    check({tag, " mflo"}, md_result, r[31:0]);
    @(negedge clk);
    md_op = 3'd5;
    #1;
    check({tag, " mfhi"}, md_result, r[63:32]);
    check({tag, " hilo"}, {hi, lo}, r);
    m_hi = r[63:32];
    m_lo = r[31:0];
    @(negedge clk);
    idle_inputs();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op, sa, sb;
    logic [31:0] a, b;
    idle_inputs();
    reg1 = 0; reg2 = 0; exmem = 0; wb = 0;
    rst_n = 1'b0;
    md_op = 3'd5;
    #12;
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst busy", busy, 0);
    check("rst stall", stall, 0);
    check("rst result", md_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();

    run_md("mult7x-3", 3'd1, 32'd7, 32'hFFFFFFFD, 3'd0, 3'd0, 1'b1);
    check("mult7x-3 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_md("divu100/7", 3'd4, 32'd100, 32'd7, 3'd0, 3'd0, 1'b0);
    check("divu const", {hi, lo}, {32'd2, 32'd14});
    run_md("div-7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 3'd0, 3'd0, 1'b0);
    check("div-7/2 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_md("divmin", 3'd3, 32'h80000000, 32'hFFFFFFFF, 3'd0, 3'd0, 1'b0);
    check("divmin const", {hi, lo}, {32'd0, 32'h80000000});
    run_md("div5/0", 3'd3, 32'd5, 32'd0, 3'd0, 3'd0, 1'b0);
    check("div0 const", {hi, lo}, {32'd5, 32'hFFFFFFFF});
    run_md("mult_fwd", 3'd1, 32'd12345, 32'hFFFF0001, 3'd1, 3'd2, 1'b0);
    run_md("multu9x1", 3'd2, 32'd9, 32'd1, 3'd0, 3'd0, 1'b0);

    // MTLO then MFLO in the following cycle, neither stalling.
    @(negedge clk);
    valid = 1'b1; md_op = 3'd7; mt_lo = 1'b1; put_operands(32'h1234, 32'd0, 3'd0, 3'd0);
    #1 check("mtlo stall", stall, 0);
    @(negedge clk);
    md_op = 3'd6; mt_lo = 1'b0;
    #1 check("mflo stall", stall, 0);
    check("mflo after mtlo", md_result, 32'h1234);
    m_lo = 32'h1234;
    @(negedge clk);
    md_op = 3'd7; mt_lo = 1'b0; put_operands(32'hCAFE0001, 32'd0, 3'd2, 3'd0);
    @(negedge clk);
    md_op = 3'd5; sel_a = 3'd0;
    #1 check("mfhi after mthi", md_result, 32'hCAFE0001);
    check("mthi keeps lo", lo, m_lo);
    m_hi = 32'hCAFE0001;
    @(negedge clk);
    idle_inputs();

    // Flush at count 10 aborts without touching HI/LO.
    @(negedge clk);
    valid = 1'b1; md_op = 3'd1; put_operands(32'd1000, 32'd3000, 3'd0, 3'd0);
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    flush = 1'b1; valid = 1'b1; md_op = 3'd1;
    @(negedge clk);
    idle_inputs();
    #1 check("flush busy", busy, 0);
    check("flush hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    check("flush no late write", {hi, lo}, {m_hi, m_lo});
    flush = 1'b1; valid = 1'b1; md_op = 3'd3; put_operands(32'd9, 32'd3, 3'd0, 3'd0);
    @(negedge clk);
    idle_inputs();
    #1 check("flush blocks start", busy, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    valid = 1'b1; md_op = 3'd2; put_operands(32'd77, 32'd88, 3'd0, 3'd0);
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 0; m_lo = 0;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = pick_val();
      b  = pick_val();
      sa = 3'($urandom_range(0, 7));
      sb = 3'($urandom_range(0, 7));
      if (sb == sa && (sa == 3'd1 || sa == 3'd2)) sb = 3'd0;
      run_md($sformatf("rnd%0d op%0d", i, op), op, a, b, sa, sb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
